// File: rtl/nios2system_onchip_memory_tester.sv
// Avalon-MM pattern fill / read-back checker for the on-chip RAM s2 port.
// A job writes expected(i) to base+i for i = 0..length-1 (unless skip_write),
// then reads the range back and counts mismatches against expected(i).
// Handshake: start is a one-cycle request honoured only in IDLE; busy is high
// while the job runs, done pulses for one cycle when it ends. The memory side
// has no waitrequest, so every chipselect cycle is one accepted transfer.
module nios2system_onchip_memory_tester #(
   parameter int ADDR_WIDTH   = 15,
   parameter int DATA_WIDTH   = 32,
   parameter int DEPTH        = 22500,
   parameter int READ_LATENCY = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [ADDR_WIDTH-1:0]   base_addr,
   input  logic [ADDR_WIDTH:0]     length,
   input  logic [DATA_WIDTH-1:0]   pattern,
   input  logic                    mode,
   input  logic                    skip_write,
   output logic                    busy,
   output logic                    done,
   output logic                    cfg_err,
   output logic [15:0]             error_count,
   output logic [ADDR_WIDTH-1:0]   first_err_addr,
   output logic [ADDR_WIDTH-1:0]   address,
   output logic [DATA_WIDTH/8-1:0] byteenable,
   output logic                    chipselect,
   output logic                    write,
   output logic [DATA_WIDTH-1:0]   writedata,
   input  logic [DATA_WIDTH-1:0]   readdata,
   output logic                    clken,
   output logic [2:0]              state_dbg
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_WRITE  = 3'd1,
      S_READ   = 3'd2,
      S_DRAIN  = 3'd3,
      S_FINISH = 3'd4
   } state_t;

   localparam logic [ADDR_WIDTH+1:0]   DEPTH_W    = (ADDR_WIDTH+2)'(DEPTH);
   localparam logic [1:0]              LAST_DRAIN = 2'(READ_LATENCY-1);
   localparam logic [DATA_WIDTH/8-1:0] BE_ALL     = '1;

   state_t                  state_q;
   logic                    busy_q, done_q, cfg_err_q, cs_q, wr_q, clken_q;
   logic [15:0]             err_cnt_q;
   logic [ADDR_WIDTH-1:0]   first_err_q, addr_q, base_q;
   logic [DATA_WIDTH/8-1:0] be_q;
   logic [DATA_WIDTH-1:0]   wdata_q, pat_q;
   logic [ADDR_WIDTH:0]     len_q, idx_q;
   logic                    mode_q;
   logic [1:0]              drain_q;

   // Compare pipeline: stage s holds the read issued s+1 cycles ago.
   logic [READ_LATENCY-1:0] pvld_q;
   logic [ADDR_WIDTH-1:0]   paddr_q [READ_LATENCY];
   logic [DATA_WIDTH-1:0]   pexp_q  [READ_LATENCY];

   logic [ADDR_WIDTH+1:0]   end_sum;
   logic                    reject;
   logic [ADDR_WIDTH:0]     idx_d;
   logic                    last_xfer;
   logic [DATA_WIDTH-1:0]   exp_cur, exp_d;
   logic                    miss;

   // Range check on the incoming job and the expected-data generator.
   always_comb begin
      end_sum   = {2'b00, base_addr} + {1'b0, length};
      reject    = ({2'b00, base_addr} >= DEPTH_W) || (end_sum > DEPTH_W);
      idx_d     = idx_q + (ADDR_WIDTH+1)'(1);
      last_xfer = (idx_d == len_q);
      exp_cur   = pat_q + (mode_q ? DATA_WIDTH'(idx_q) : '0);
      exp_d     = pat_q + (mode_q ? DATA_WIDTH'(idx_d) : '0);
      miss      = pvld_q[READ_LATENCY-1] && (readdata != pexp_q[READ_LATENCY-1]);
   end

   // Job sequencer: every bus and status output is a register set here.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         cfg_err_q   <= 1'b0;
         err_cnt_q   <= '0;
         first_err_q <= '0;
         addr_q      <= '0;
         be_q        <= '0;
         cs_q        <= 1'b0;
         wr_q        <= 1'b0;
         wdata_q     <= '0;
         clken_q     <= 1'b0;
         base_q      <= '0;
         len_q       <= '0;
         pat_q       <= '0;
         mode_q      <= 1'b0;
         idx_q       <= '0;
         drain_q     <= '0;
      end else begin
         clken_q <= 1'b1;
         done_q  <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  base_q      <= base_addr;
                  len_q       <= length;
                  pat_q       <= pattern;
                  mode_q      <= mode;
                  idx_q       <= '0;
                  err_cnt_q   <= '0;
                  first_err_q <= '0;
                  cfg_err_q   <= reject;
                  if (reject || (length == '0)) begin
                     state_q <= S_FINISH;
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                  end else begin
                     // Transfer 0 goes on the bus in the very next cycle.
                     busy_q  <= 1'b1;
                     cs_q    <= 1'b1;
                     be_q    <= BE_ALL;
                     addr_q  <= base_addr;
                     wdata_q <= pattern;
                     wr_q    <= ~skip_write;
                     state_q <= skip_write ? S_READ : S_WRITE;
                  end
               end
            end
            S_WRITE: begin
               if (last_xfer) begin
                  state_q <= S_READ;
                  idx_q   <= '0;
                  addr_q  <= base_q;
                  wr_q    <= 1'b0;
               end else begin
                  idx_q   <= idx_d;
                  addr_q  <= addr_q + ADDR_WIDTH'(1);
                  wdata_q <= exp_d;
               end
            end
            S_READ: begin
               if (last_xfer) begin
                  state_q <= S_DRAIN;
                  cs_q    <= 1'b0;
                  be_q    <= '0;
                  drain_q <= '0;
               end else begin
                  idx_q  <= idx_d;
                  addr_q <= addr_q + ADDR_WIDTH'(1);
               end
            end
            S_DRAIN: begin
               // Leave once the final read's compare lands at this edge.
               if (drain_q == LAST_DRAIN) begin
                  state_q <= S_FINISH;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
               end else begin
                  drain_q <= drain_q + 2'd1;
               end
            end
            S_FINISH: state_q <= S_IDLE;
            default:  state_q <= S_IDLE;
         endcase
         // Pipeline is empty in IDLE, so this never races the start-time clear.
         if (miss) begin
            if (err_cnt_q == '0) first_err_q <= paddr_q[READ_LATENCY-1];
            if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
         end
      end
   end

   // Carry each read's address and expected data alongside the slave latency.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pvld_q <= '0;
         for (int s = 0; s < READ_LATENCY; s++) begin
            paddr_q[s] <= '0;
            pexp_q[s]  <= '0;
         end
      end else begin
         pvld_q[0]  <= (state_q == S_READ);
         paddr_q[0] <= addr_q;
         pexp_q[0]  <= exp_cur;
         for (int s = 1; s < READ_LATENCY; s++) begin
            pvld_q[s]  <= pvld_q[s-1];
            paddr_q[s] <= paddr_q[s-1];
            pexp_q[s]  <= pexp_q[s-1];
         end
      end
   end

   assign busy           = busy_q;
   assign done           = done_q;
   assign cfg_err        = cfg_err_q;
   assign error_count    = err_cnt_q;
   assign first_err_addr = first_err_q;
   assign address        = addr_q;
   assign byteenable     = be_q;
   assign chipselect     = cs_q;
   assign write          = wr_q;
   assign writedata      = wdata_q;
   assign clken          = clken_q;
   assign state_dbg      = state_q;

endmodule

// File: tb/tb_nios2system_onchip_memory_tester.sv
// Bench for nios2system_onchip_memory_tester: behavioural RAM slave with two
// stuck bit faults, a job-level reference model, and a transfer monitor.
module tb_nios2system_onchip_memory_tester;

   localparam int AW    = 15;
   localparam int DW    = 32;
   localparam int DEPTH = 22500;
   localparam int RL    = 1;

   logic          clk, reset, start, mode, skip_write;
   logic [AW-1:0] base_addr;
   logic [AW:0]   length;
   logic [DW-1:0] pattern, writedata, readdata;
   logic          busy, done, cfg_err, chipselect, write, clken;
   logic [15:0]   error_count;
   logic [AW-1:0] first_err_addr, address;
   logic [3:0]    byteenable;
   logic [2:0]    state_dbg;

   nios2system_onchip_memory_tester #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .READ_LATENCY(RL)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
      .length(length), .pattern(pattern), .mode(mode), .skip_write(skip_write),
      .busy(busy), .done(done), .cfg_err(cfg_err), .error_count(error_count),
      .first_err_addr(first_err_addr), .address(address),
      .byteenable(byteenable), .chipselect(chipselect), .write(write),
      .writedata(writedata), .readdata(readdata), .clken(clken),
      .state_dbg(state_dbg)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- slave RAM model ----------------
   logic [DW-1:0] mem     [0:DEPTH-1];
   logic [DW-1:0] ref_mem [0:DEPTH-1];

   function automatic logic [DW-1:0] fault_mask(input int a);
      return (a == 205 || a == 210) ? 32'h1 : 32'h0;
   endfunction

   always @(posedge clk) begin
      if (chipselect && write) mem[int'(address)] <= writedata;
      if (chipselect && !write) readdata <= mem[int'(address)] ^ fault_mask(int'(address));
   end

   // ---------------- monitor ----------------
   logic [95:0] obs_q[$];
   int          done_cyc_q[$];
   int          be_bad = 0;

   always @(negedge clk) begin
      if (chipselect) begin
         obs_q.push_back({32'(cyc), write, address, (write ? writedata : 32'h0)});
         if (byteenable !== 4'hF) be_bad = be_bad + 1;
      end
      if (done) done_cyc_q.push_back(cyc);
   end

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ---------------- driver + reference model ----------------
   task automatic run_job(input int base, input int len, input logic [31:0] pat,
                          input logic md, input logic skip, input logic dbl);
      logic [95:0]   exp_q[$];
      int            t, off, done_exp, errs, first, o0, d0, k;
      logic          rej;
      logic [DW-1:0] ev, rv;

      rej = (base >= DEPTH) || (base + len > DEPTH);
      @(negedge clk);
      o0 = obs_q.size();
      d0 = done_cyc_q.size();
      base_addr  = base[AW-1:0];
      length     = len[AW:0];
      pattern    = pat;
      mode       = md;
      skip_write = skip;
      start      = 1'b1;
      t          = cyc;
      @(negedge clk);
      start = 1'b0;
      check("busy_t1", busy, (!rej && len > 0));
      if (dbl && !rej && len >= 2) begin
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
      k = 0;
      while (done_cyc_q.size() == d0 && k < 2 * len + RL + 20) begin
         @(posedge clk);
         k++;
      end
      repeat (4) @(negedge clk);
      #1;

      // Job-level model: transfer list, done cycle and mismatch statistics.
      errs = 0;
      first = 0;
      off = skip ? 0 : len;
      if (!rej && len > 0) begin
         if (!skip) begin
            for (int i = 0; i < len; i++) begin
               ev = pat + (md ? 32'(i) : 32'h0);
               exp_q.push_back({32'(t + 1 + i), 1'b1, 15'(base + i), ev});
               ref_mem[base + i] = ev;
            end
         end
         for (int i = 0; i < len; i++) begin
            ev = pat + (md ? 32'(i) : 32'h0);
            exp_q.push_back({32'(t + off + 1 + i), 1'b0, 15'(base + i), 32'h0});
            rv = ref_mem[base + i] ^ fault_mask(base + i);
            if (rv != ev) begin
               if (errs == 0) first = base + i;
               if (errs < 65535) errs++;
            end
         end
         done_exp = t + off + len + RL + 1;
      end else begin
         done_exp = t + 1;
      end

      check("done_count", done_cyc_q.size() - d0, 1);
      if (done_cyc_q.size() > d0) check("done_cycle", done_cyc_q[d0], done_exp);
      check("xfer_count", obs_q.size() - o0, exp_q.size());
      for (int i = 0; i < exp_q.size() && (o0 + i) < obs_q.size(); i++)
         check("xfer", obs_q[o0 + i], exp_q[i]);
      check("busy_end", busy, 0);
      check("cfg_err", cfg_err, rej);
      check("error_count", error_count, errs);
      check("first_err_addr", first_err_addr, first);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int t, o0, b, l;
      for (int i = 0; i < DEPTH; i++) begin
         mem[i]     = '0;
         ref_mem[i] = '0;
      end
      reset = 1'b1; start = 1'b0; mode = 1'b0; skip_write = 1'b0;
      base_addr = '0; length = '0; pattern = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_cfg_err", cfg_err, 0);
      check("rst_err_cnt", error_count, 0);
      check("rst_first", first_err_addr, 0);
      check("rst_bus", {address, byteenable, chipselect, write, writedata}, 0);
      check("rst_clken", clken, 0);
      reset = 1'b0;
      @(negedge clk);
      check("clken_run", clken, 1);

      // Directed jobs
      run_job(100, 8, 32'hA5A5A5A5, 1'b0, 1'b0, 1'b0);
      run_job(0, 4, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b0);
      run_job(200, 16, 32'h12345678, 1'b1, 1'b0, 1'b0);
      check("fault_cnt", error_count, 2);
      check("fault_first", first_err_addr, 205);
      run_job(22499, 1, 32'hCAFEF00D, 1'b0, 1'b0, 1'b0);
      run_job(22499, 2, 32'hCAFEF00D, 1'b0, 1'b0, 1'b0);
      check("reject_cfg", cfg_err, 1);
      run_job(50, 0, 32'h0BADBEEF, 1'b0, 1'b0, 1'b0);
      run_job(300, 6, 32'h00000010, 1'b1, 1'b0, 1'b1);

      // Reset during READ of a verify-only job over unwritten memory
      @(negedge clk);
      base_addr = 15'd1000; length = 16'd16; pattern = 32'hDEADBEEF;
      mode = 1'b1; skip_write = 1'b1; start = 1'b1;
      t = cyc;
      @(negedge clk);
      start = 1'b0;
      while (cyc < t + 10) @(negedge clk);
      check("pre_rst_errs", error_count, 8);
      check("pre_rst_first", first_err_addr, 1000);
      reset = 1'b1;
      #1;
      check("mid_rst_cs", chipselect, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_errs", error_count, 0);
      check("mid_rst_clken", clken, 0);
      o0 = obs_q.size();
      repeat (3) @(negedge clk);
      #1;
      check("mid_rst_no_xfer", obs_q.size() - o0, 0);
      @(negedge clk);
      reset = 1'b0;
      run_job(0, 2, 32'h55AA55AA, 1'b0, 1'b0, 1'b0);

      // Randomized jobs
      for (int j = 0; j < 25; j++) begin
         if ($urandom_range(0, 4) == 0) b = 22470 + int'($urandom_range(0, 40));
         else b = int'($urandom_range(0, 22000));
         l = int'($urandom_range(0, 40));
         run_job(b, l, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 3) == 0));
      end

      check("byteenable", be_bad, 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
